tx_gear_40_10: RTL and testbench

- Per-lane 40-to-10 transmit gearbox that sits directly upstream of the 20-lane LVDS transmit wrapper.
- Accepts 40-bit words from core logic over a valid/ready handshake and buffers them in a small FIFO.
- Emits one 10-bit slice per I_clk cycle to the serializer input, plus the matching 2-bit slice select.
- Qualifies serializer PLL lock, sends a training pattern after lock, and inserts idle words on underrun.

---
 rtl/tx_gear_40_10.sv | 208 ++++++++++++++++++++
 tb/tb_tx_gear_40_10.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gear_40_10.sv
// Per-lane 40-to-10 transmit gearbox: word FIFO, PLL lock qualification,
// training sequence and idle insertion ahead of the LVDS serializer.
module tx_gear_40_10 #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          LOCK_WAIT   = 16,
    parameter int          TRAIN_WORDS = 8,
    parameter logic [9:0]  TRAIN_PAT   = 10'h3E0
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_tx_locked,
    input  logic [39:0] I_data,
    input  logic        I_valid,
    output logic        O_ready,
    output logic [9:0]  O_data,
    output logic [1:0]  O_sel,
    output logic        O_frame,
    output logic        O_link_up,
    output logic [15:0] O_idle_cnt
);

    localparam int AW  = (FIFO_DEPTH > 1)  ? $clog2(FIFO_DEPTH)  : 1;
    localparam int LCW = (LOCK_WAIT > 1)   ? $clog2(LOCK_WAIT)   : 1;
    localparam int TCW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

    localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_WAIT - 1);
    localparam logic [LCW-1:0] LOCK_ONE   = LCW'(1);
    localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_WORDS - 1);
    localparam logic [TCW-1:0] TRAIN_ONE  = TCW'(1);
    localparam logic [AW:0]    PTR_ONE    = (AW + 1)'(1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_TRAIN     = 2'd1;
    localparam logic [1:0] ST_DATA      = 2'd2;

    localparam logic [39:0] IDLE_WORD = {TRAIN_PAT, TRAIN_PAT, TRAIN_PAT, TRAIN_PAT};

    function automatic logic [9:0] slice_at(input logic [39:0] word, input logic [1:0] idx);
        logic [9:0] s;
        case (idx)
            2'd0:    s = word[9:0];
            2'd1:    s = word[19:10];
            2'd2:    s = word[29:20];
            default: s = word[39:30];
        endcase
        return s;
    endfunction

    function automatic logic ptr_full(input logic [AW:0] wr, input logic [AW:0] rd);
        return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    logic [1:0]     state_r,     state_nxt_s;
    logic [LCW-1:0] lock_cnt_r,  lock_cnt_nxt_s;
    logic [TCW-1:0] train_cnt_r, train_cnt_nxt_s;
    logic [1:0]     sel_r,       sel_nxt_s;
    logic [9:0]     data_r,      data_nxt_s;
    logic           frame_r,     frame_nxt_s;
    logic           ready_r,     ready_nxt_s;
    logic           link_up_r,   link_up_nxt_s;
    logic [15:0]    idle_cnt_r,  idle_cnt_nxt_s;
    logic [39:0]    shreg_r,     shreg_nxt_s;
    logic [AW:0]    wr_ptr_r,    wr_ptr_nxt_s;
    logic [AW:0]    rd_ptr_r,    rd_ptr_nxt_s;
    logic [39:0]    mem_r [FIFO_DEPTH];

    logic           empty_s;
    logic           push_s;
    logic           pop_s;
    logic [39:0]    head_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = I_valid && ready_r;
    assign pop_s   = I_tx_locked && (state_r == ST_DATA) && (sel_r == 2'd3) && !empty_s;
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

    // Next-state logic for the link FSM, slice sequencer and FIFO pointers.
    always_comb begin
        state_nxt_s     = state_r;
        lock_cnt_nxt_s  = lock_cnt_r;
        train_cnt_nxt_s = train_cnt_r;
        sel_nxt_s       = sel_r;
        data_nxt_s      = data_r;
        frame_nxt_s     = 1'b0;
        shreg_nxt_s     = shreg_r;
        idle_cnt_nxt_s  = idle_cnt_r;
        wr_ptr_nxt_s    = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s    = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

        if (!I_tx_locked) begin
            // Lock loss drops the partial word and flushes the FIFO.
            state_nxt_s     = ST_WAIT_LOCK;
            lock_cnt_nxt_s  = '0;
            train_cnt_nxt_s = '0;
            sel_nxt_s       = 2'd0;
            data_nxt_s      = TRAIN_PAT;
            wr_ptr_nxt_s    = '0;
            rd_ptr_nxt_s    = '0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    sel_nxt_s  = 2'd0;
                    data_nxt_s = TRAIN_PAT;
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_nxt_s     = ST_TRAIN;
                        lock_cnt_nxt_s  = '0;
                        train_cnt_nxt_s = '0;
                    end else begin
                        lock_cnt_nxt_s = lock_cnt_r + LOCK_ONE;
                    end
                end
                ST_TRAIN: begin
                    data_nxt_s = TRAIN_PAT;
                    if (sel_r == 2'd3) begin
                        if (train_cnt_r == TRAIN_LAST) begin
                            // Hold O_sel at 3 so the DATA entry cycle is itself a word boundary.
                            state_nxt_s = ST_DATA;
                        end else begin
                            train_cnt_nxt_s = train_cnt_r + TRAIN_ONE;
                            sel_nxt_s       = 2'd0;
                        end
                    end else begin
                        sel_nxt_s = sel_r + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (sel_r == 2'd3) begin
                        sel_nxt_s = 2'd0;
                        if (!empty_s) begin
                            shreg_nxt_s = head_s;
                            data_nxt_s  = head_s[9:0];
                            frame_nxt_s = 1'b1;
                        end else begin
                            shreg_nxt_s    = IDLE_WORD;
                            data_nxt_s     = TRAIN_PAT;
                            idle_cnt_nxt_s = (idle_cnt_r != 16'hFFFF) ? (idle_cnt_r + 16'd1) : idle_cnt_r;
                        end
                    end else begin
                        sel_nxt_s  = sel_r + 2'd1;
                        data_nxt_s = slice_at(shreg_r, sel_r + 2'd1);
                    end
                end
                default: begin
                    state_nxt_s    = ST_WAIT_LOCK;
                    lock_cnt_nxt_s = '0;
                    sel_nxt_s      = 2'd0;
                    data_nxt_s     = TRAIN_PAT;
                    wr_ptr_nxt_s   = '0;
                    rd_ptr_nxt_s   = '0;
                end
            endcase
        end

        // Ready is registered, so it is derived from the post-edge occupancy and state.
        ready_nxt_s   = (state_nxt_s != ST_WAIT_LOCK) && !ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
        link_up_nxt_s = (state_nxt_s == ST_DATA);
    end

    // Control, output and pointer registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r     <= ST_WAIT_LOCK;
            lock_cnt_r  <= '0;
            train_cnt_r <= '0;
            sel_r       <= 2'd0;
            data_r      <= TRAIN_PAT;
            frame_r     <= 1'b0;
            ready_r     <= 1'b0;
            link_up_r   <= 1'b0;
            idle_cnt_r  <= 16'd0;
            shreg_r     <= IDLE_WORD;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            lock_cnt_r  <= lock_cnt_nxt_s;
            train_cnt_r <= train_cnt_nxt_s;
            sel_r       <= sel_nxt_s;
            data_r      <= data_nxt_s;
            frame_r     <= frame_nxt_s;
            ready_r     <= ready_nxt_s;
            link_up_r   <= link_up_nxt_s;
            idle_cnt_r  <= idle_cnt_nxt_s;
            shreg_r     <= shreg_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= I_data;
        end
    end

    assign O_ready    = ready_r;
    assign O_data     = data_r;
    assign O_sel      = sel_r;
    assign O_frame    = frame_r;
    assign O_link_up  = link_up_r;
    assign O_idle_cnt = idle_cnt_r;

endmodule

// File: tb/tb_tx_gear_40_10.sv
// Directed self-checking bench for tx_gear_40_10: lock qualification, training,
// data slicing, streaming, underrun idles, lock loss and asynchronous reset.
module tb_tx_gear_40_10;

    localparam logic [9:0] PAT = 10'h3E0;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_tx_locked = 1'b0;
    logic [39:0] I_data = 40'd0;
    logic        I_valid = 1'b0;
    logic        O_ready;
    logic [9:0]  O_data;
    logic [1:0]  O_sel;
    logic        O_frame;
    logic        O_link_up;
    logic [15:0] O_idle_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    tx_gear_40_10 dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_tx_locked (I_tx_locked),
        .I_data      (I_data),
        .I_valid     (I_valid),
        .O_ready     (O_ready),
        .O_data      (O_data),
        .O_sel       (O_sel),
        .O_frame     (O_frame),
        .O_link_up   (O_link_up),
        .O_idle_cnt  (O_idle_cnt)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Word i carries slices 256+4i .. 256+4i+3, slice 0 in the low bits.
    function automatic logic [39:0] make_word(input int i);
        logic [9:0] b;
        b = 10'(256 + 4 * i);
        return {b + 10'd3, b + 10'd2, b + 10'd1, b};
    endfunction

    task automatic step();
        @(posedge I_clk);
        @(negedge I_clk);
    endtask

    task automatic do_reset();
        I_rst_n = 1'b0;
        I_tx_locked = 1'b0;
        I_valid = 1'b0;
        step();
        step();
        I_rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [39:0] w);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        I_data = w;
        I_valid = 1'b1;
        while (!acc && n < 64) begin
            acc = O_ready;
            step();
            n++;
        end
        total_cnt++;
        if (!acc) $display("FAIL push_accept: word %h accepted=%b, want 1", w, acc);
        else pass_cnt++;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (O_frame !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total_cnt++;
        if (O_frame !== 1'b1) $display("FAIL %s: frame=%b after %0d cycles, want 1", name, O_frame, n);
        else pass_cnt++;
    endtask

    task automatic lock_to_train();
        I_tx_locked = 1'b1;
        repeat (16) step();
        total_cnt++;
        if (O_ready !== 1'b1 || O_sel !== 2'd0)
            $display("FAIL train_entry: ready=%b sel=%0d, want ready=1 sel=0", O_ready, O_sel);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        I_rst_n = 1'b0;
        step();
        total_cnt++;
        if (O_ready !== 1'b0 || O_data !== PAT || O_sel !== 2'd0 || O_frame !== 1'b0 ||
            O_link_up !== 1'b0 || O_idle_cnt !== 16'd0)
            $display("FAIL reset_hold: ready=%b data=%h sel=%0d frame=%b link=%b idle=%0d, want 0 3e0 0 0 0 0",
                     O_ready, O_data, O_sel, O_frame, O_link_up, O_idle_cnt);
        else pass_cnt++;
        I_rst_n = 1'b1;
        step();
        total_cnt++;
        if (O_ready !== 1'b0 || O_data !== PAT || O_sel !== 2'd0 || O_link_up !== 1'b0)
            $display("FAIL reset_release: ready=%b data=%h sel=%0d link=%b, want 0 3e0 0 0",
                     O_ready, O_data, O_sel, O_link_up);
        else pass_cnt++;
    endtask

    task automatic test_lock_qual();
        I_tx_locked = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            total_cnt++;
            if (O_ready !== 1'b0 || O_data !== PAT || O_sel !== 2'd0)
                $display("FAIL lock_run1[%0d]: ready=%b data=%h sel=%0d, want 0 3e0 0", i, O_ready, O_data, O_sel);
            else pass_cnt++;
        end
        I_tx_locked = 1'b0;
        step();
        I_tx_locked = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            total_cnt++;
            if (O_ready !== 1'b0 || O_data !== PAT)
                $display("FAIL lock_run2[%0d]: ready=%b data=%h, want 0 3e0", i, O_ready, O_data);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (O_ready !== 1'b1 || O_sel !== 2'd0 || O_link_up !== 1'b0)
            $display("FAIL lock_train_entry: ready=%b sel=%0d link=%b, want 1 0 0", O_ready, O_sel, O_link_up);
        else pass_cnt++;
        for (int i = 1; i < 32; i++) begin
            step();
            total_cnt++;
            if (O_link_up !== 1'b0 || O_data !== PAT || O_sel !== 2'(i % 4))
                $display("FAIL train_slice[%0d]: link=%b data=%h sel=%0d, want 0 3e0 %0d",
                         i, O_link_up, O_data, O_sel, i % 4);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (O_link_up !== 1'b1)
            $display("FAIL link_up_rise: link=%b 32 cycles after training start, want 1", O_link_up);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        logic [9:0] exp [4];
        exp = '{10'h345, 10'h048, 10'h0DE, 10'h2AF};
        push_word(40'hABCDE_12345);
        I_valid = 1'b0;
        wait_frame("single_frame");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            total_cnt++;
            if (O_data !== exp[k] || O_sel !== 2'(k) || O_frame !== (k == 0))
                $display("FAIL single_slice[%0d]: data=%h sel=%0d frame=%b, want %h %0d %b",
                         k, O_data, O_sel, O_frame, exp[k], k, (k == 0));
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        I_tx_locked = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) push_word(make_word(i));
                I_valid = 1'b0;
            end
            begin
                wait_frame("b2b_frame");
                for (int j = 0; j < 48; j++) begin
                    if (j > 0) step();
                    total_cnt++;
                    if (O_data !== 10'(256 + j) || O_sel !== 2'(j % 4) || O_frame !== (j % 4 == 0))
                        $display("FAIL b2b_slice[%0d]: data=%h sel=%0d frame=%b, want %h %0d %b",
                                 j, O_data, O_sel, O_frame, 10'(256 + j), j % 4, (j % 4 == 0));
                    else pass_cnt++;
                end
                total_cnt++;
                if (O_idle_cnt !== 16'd0)
                    $display("FAIL b2b_idle_cnt: idle=%0d, want 0", O_idle_cnt);
                else pass_cnt++;
            end
        join
    endtask

    task automatic test_underrun();
        do_reset();
        lock_to_train();
        push_word(make_word(20));
        push_word(make_word(21));
        I_valid = 1'b0;
        wait_frame("underrun_frame");
        for (int j = 0; j < 8; j++) begin
            if (j > 0) step();
            total_cnt++;
            if (O_data !== 10'(336 + j) || O_frame !== (j % 4 == 0) || O_idle_cnt !== 16'd0)
                $display("FAIL underrun_data[%0d]: data=%h frame=%b idle=%0d, want %h %b 0",
                         j, O_data, O_frame, O_idle_cnt, 10'(336 + j), (j % 4 == 0));
            else pass_cnt++;
        end
        for (int k = 0; k < 8; k++) begin
            step();
            total_cnt++;
            if (O_data !== PAT || O_frame !== 1'b0 || O_sel !== 2'(k % 4) || O_idle_cnt !== 16'(1 + k / 4))
                $display("FAIL underrun_idle[%0d]: data=%h frame=%b sel=%0d idle=%0d, want 3e0 0 %0d %0d",
                         k, O_data, O_frame, O_sel, O_idle_cnt, k % 4, 1 + k / 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        lock_to_train();
        for (int i = 30; i < 34; i++) push_word(make_word(i));
        I_valid = 1'b0;
        total_cnt++;
        if (O_ready !== 1'b0) $display("FAIL ll_full: ready=%b with 4 words queued, want 0", O_ready);
        else pass_cnt++;
        wait_frame("ll_frame");
        step();
        total_cnt++;
        if (O_sel !== 2'd1 || O_data !== 10'(376 + 1))
            $display("FAIL ll_mid_word: sel=%0d data=%h, want 1 %h", O_sel, O_data, 10'(377));
        else pass_cnt++;
        I_tx_locked = 1'b0;
        step();
        total_cnt++;
        if (O_data !== PAT || O_sel !== 2'd0 || O_ready !== 1'b0 || O_link_up !== 1'b0 || O_frame !== 1'b0)
            $display("FAIL ll_drop: data=%h sel=%0d ready=%b link=%b frame=%b, want 3e0 0 0 0 0",
                     O_data, O_sel, O_ready, O_link_up, O_frame);
        else pass_cnt++;
        I_tx_locked = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            total_cnt++;
            if (O_ready !== 1'b0) $display("FAIL ll_relock_wait[%0d]: ready=%b, want 0", i, O_ready);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (O_ready !== 1'b1) $display("FAIL ll_retrain: ready=%b, want 1", O_ready);
        else pass_cnt++;
        repeat (32) step();
        total_cnt++;
        if (O_link_up !== 1'b1) $display("FAIL ll_link_up: link=%b, want 1", O_link_up);
        else pass_cnt++;
        step();
        total_cnt++;
        if (O_data !== PAT || O_frame !== 1'b0 || O_sel !== 2'd0 || O_idle_cnt !== 16'd1)
            $display("FAIL ll_flushed: data=%h frame=%b sel=%0d idle=%0d, want 3e0 0 0 1",
                     O_data, O_frame, O_sel, O_idle_cnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        repeat (6) step();
        #2;
        I_rst_n = 1'b0;
        #1;
        total_cnt++;
        if (O_ready !== 1'b0 || O_data !== PAT || O_sel !== 2'd0 || O_frame !== 1'b0 ||
            O_link_up !== 1'b0 || O_idle_cnt !== 16'd0)
            $display("FAIL async_reset: ready=%b data=%h sel=%0d frame=%b link=%b idle=%0d, want 0 3e0 0 0 0 0",
                     O_ready, O_data, O_sel, O_frame, O_link_up, O_idle_cnt);
        else pass_cnt++;
        @(negedge I_clk);
        I_tx_locked = 1'b0;
        I_rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_lock_qual();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_lock_loss();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
